wave_gen: RTL



---
 rtl/wave_gen_if.sv | 24 ++
 rtl/wave_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/wave_gen_if.sv
// Control and sample bus of the phase-accumulator waveform generator.
// The driver owns the pending settings and the generator owns the sample outputs.
interface wave_gen_if #(
  parameter int ACC_W = 16
);
  logic             en;
  logic             phase_clr;
  logic [ACC_W-1:0] freq_step;
  logic [1:0]       wave_sel;
  logic [7:0]       duty;
  logic [7:0]       out;
  logic             out_valid;
  logic             wrap;

  modport master (
    output en, phase_clr, freq_step, wave_sel, duty,
    input  out, out_valid, wrap
  );

  modport slave (
    input  en, phase_clr, freq_step, wave_sel, duty,
    output out, out_valid, wrap
  );
endinterface

// File: rtl/wave_gen.sv
// Phase-accumulator generator: saw, triangle, square and parabolic sine, 8-bit signed samples.
// One sample per prescaler tick, one clock after the tick; settings commit only at period wrap.
module wave_gen #(
  parameter int ACC_W = 16,
  parameter int DIV   = 1
) (
  input  logic      clk,
  input  logic      rst,
  wave_gen_if.slave bus
);

  localparam int              PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_step;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_sel;
  logic [7:0]       r_duty;
  logic [7:0]       r_out;
  logic             r_vld;
  logic             r_wrap;

  logic             w_tick;
  logic             w_carry;
  logic             w_commit;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [1:0]       w_sel;
  logic [7:0]       w_duty;
  logic [7:0]       w_p;
  logic [7:0]       w_tri;
  logic [11:0]      w_q;
  logic [11:0]      w_m;
  logic [7:0]       w_mag;
  logic [7:0]       w_sample;

  assign w_tick = bus.en && (r_pre == PRE_LAST);

  assign {w_carry, w_acc_nxt} = {1'b0, r_acc} + {1'b0, r_step};

  // A zero step never carries, so it commits on every tick to let a new step in.
  assign w_commit = w_carry || (r_step == '0);
  assign w_sel    = w_commit ? bus.wave_sel : r_sel;
  assign w_duty   = w_commit ? bus.duty     : r_duty;

  assign w_p   = w_acc_nxt[ACC_W-1 -: 8];
  assign w_tri = w_p[7] ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
  assign w_q   = {5'd0, w_p[6:0]};
  assign w_m   = w_q * (12'd127 - w_q);
  assign w_mag = 8'(w_m >> 5);

  always_comb begin
    w_sample = 8'h00;
    case (w_sel)
      2'b00:   w_sample = w_p ^ 8'h80;
      2'b01:   w_sample = w_tri ^ 8'h80;
      2'b10:   w_sample = (w_p < w_duty) ? 8'h7F : 8'h80;
      default: w_sample = w_p[7] ? -w_mag : w_mag;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_pre  <= '0;
      r_step <= '0;
      r_sel  <= 2'b00;
      r_duty <= 8'h00;
      r_out  <= 8'h00;
      r_vld  <= 1'b0;
      r_wrap <= 1'b0;
    end else if (bus.phase_clr) begin
      r_acc  <= '0;
      r_pre  <= '0;
      r_step <= bus.freq_step;
      r_sel  <= bus.wave_sel;
      r_duty <= bus.duty;
      r_vld  <= 1'b0;
      r_wrap <= 1'b0;
    end else if (!bus.en) begin
      r_step <= bus.freq_step;
      r_sel  <= bus.wave_sel;
      r_duty <= bus.duty;
      r_vld  <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_tick) begin
      r_pre  <= '0;
      r_acc  <= w_acc_nxt;
      r_wrap <= w_carry;
      r_vld  <= 1'b1;
      r_out  <= w_sample;
      if (w_commit) begin
        r_step <= bus.freq_step;
        r_sel  <= bus.wave_sel;
        r_duty <= bus.duty;
      end
    end else begin
      r_pre  <= r_pre + 1'b1;
      r_vld  <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_vld;
  assign bus.wrap      = r_wrap;

endmodule
